// File: rtl/decode_stage_if.sv
// Decode stage bus interface.
// Groups every non-clock/reset signal of the decode stage:
//   fetch fields   f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat
//   control        D_stall, D_bubble, E_bubble
//   reg-file read  d_srcA, d_srcB (addresses out), valA, valB (data in)
//   forwards       e_dstE/e_valE, M_dstM/m_valM, M_dstE/M_valE,
//                  W_dstM/W_valM, W_dstE/W_valE
//   E register     E_icode, E_ifun, E_stat, E_valC, E_valA, E_valB,
//                  E_dstE, E_dstM, E_srcA, E_srcB
//   hazard         d_loaduse
// The slave modport is the decode stage; master is its surrounding pipeline.
interface decode_stage_if;
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic [3:0]  f_rA;
    logic [3:0]  f_rB;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic [2:0]  f_stat;

    logic        D_stall;
    logic        D_bubble;
    logic        E_bubble;

    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [63:0] valA;
    logic [63:0] valB;

    logic [3:0]  e_dstE;
    logic [63:0] e_valE;
    logic [3:0]  M_dstM;
    logic [63:0] m_valM;
    logic [3:0]  M_dstE;
    logic [63:0] M_valE;
    logic [3:0]  W_dstM;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [63:0] W_valE;

    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [2:0]  E_stat;
    logic [63:0] E_valC;
    logic [63:0] E_valA;
    logic [63:0] E_valB;
    logic [3:0]  E_dstE;
    logic [3:0]  E_dstM;
    logic [3:0]  E_srcA;
    logic [3:0]  E_srcB;

    logic        d_loaduse;

    modport master (
        output f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat,
        output D_stall, D_bubble, E_bubble,
        output valA, valB,
        output e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
        output W_dstM, W_valM, W_dstE, W_valE,
        input  d_srcA, d_srcB,
        input  E_icode, E_ifun, E_stat, E_valC, E_valA, E_valB,
        input  E_dstE, E_dstM, E_srcA, E_srcB,
        input  d_loaduse
    );

    modport slave (
        input  f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat,
        input  D_stall, D_bubble, E_bubble,
        input  valA, valB,
        input  e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
        input  W_dstM, W_valM, W_dstE, W_valE,
        output d_srcA, d_srcB,
        output E_icode, E_ifun, E_stat, E_valC, E_valA, E_valB,
        output E_dstE, E_dstM, E_srcA, E_srcB,
        output d_loaduse
    );
endinterface

// File: rtl/decode_stage.sv
// Y86-64 style decode stage: the D pipeline register, register-file address
// generation, operand forwarding, the D/E pipeline register and the
// load-use hazard flag.
// Ports:
//   clk_i  - clock, all state updates on its rising edge
//   rst_i  - asynchronous active-high reset, forces D and E to bubbles
//   bus    - decode_stage_if.slave, fetch fields in, register-file
//            addresses/data, forwards, E register and d_loaduse out
module decode_stage (
    input  logic          clk_i,
    input  logic          rst_i,
    decode_stage_if.slave bus
);
    localparam logic [3:0] REG_NONE = 4'hf;
    localparam logic [3:0] REG_RSP  = 4'h4;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;

    // D register
    logic [3:0]  dreg_icode_q, dreg_icode_d;
    logic [3:0]  dreg_ifun_q,  dreg_ifun_d;
    logic [3:0]  dreg_ra_q,    dreg_ra_d;
    logic [3:0]  dreg_rb_q,    dreg_rb_d;
    logic [63:0] dreg_valc_q,  dreg_valc_d;
    logic [63:0] dreg_valp_q,  dreg_valp_d;
    logic [2:0]  dreg_stat_q,  dreg_stat_d;

    // E register
    logic [3:0]  ereg_icode_q, ereg_icode_d;
    logic [3:0]  ereg_ifun_q,  ereg_ifun_d;
    logic [2:0]  ereg_stat_q,  ereg_stat_d;
    logic [63:0] ereg_valc_q,  ereg_valc_d;
    logic [63:0] ereg_vala_q,  ereg_vala_d;
    logic [63:0] ereg_valb_q,  ereg_valb_d;
    logic [3:0]  ereg_dste_q,  ereg_dste_d;
    logic [3:0]  ereg_dstm_q,  ereg_dstm_d;
    logic [3:0]  ereg_srca_q,  ereg_srca_d;
    logic [3:0]  ereg_srcb_q,  ereg_srcb_d;

    // Decode results
    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] d_val_a, d_val_b;

    // D register next state: stall wins over bubble, otherwise capture fetch.
    always_comb begin
        dreg_icode_d = dreg_icode_q;
        dreg_ifun_d  = dreg_ifun_q;
        dreg_ra_d    = dreg_ra_q;
        dreg_rb_d    = dreg_rb_q;
        dreg_valc_d  = dreg_valc_q;
        dreg_valp_d  = dreg_valp_q;
        dreg_stat_d  = dreg_stat_q;
        if (!bus.D_stall) begin
            if (bus.D_bubble) begin
                dreg_icode_d = I_NOP;
                dreg_ifun_d  = 4'h0;
                dreg_ra_d    = REG_NONE;
                dreg_rb_d    = REG_NONE;
                dreg_valc_d  = 64'h0;
                dreg_valp_d  = 64'h0;
                dreg_stat_d  = STAT_AOK;
            end else begin
                dreg_icode_d = bus.f_icode;
                dreg_ifun_d  = bus.f_ifun;
                dreg_ra_d    = bus.f_rA;
                dreg_rb_d    = bus.f_rB;
                dreg_valc_d  = bus.f_valC;
                dreg_valp_d  = bus.f_valP;
                dreg_stat_d  = bus.f_stat;
            end
        end
    end

    // Register-file addresses and destinations by instruction class.
    always_comb begin
        src_a = REG_NONE;
        src_b = REG_NONE;
        dst_e = REG_NONE;
        dst_m = REG_NONE;
        case (dreg_icode_q)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = dreg_ra_q;
            I_RET, I_POPQ:                      src_a = REG_RSP;
            default:                            src_a = REG_NONE;
        endcase
        case (dreg_icode_q)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = dreg_rb_q;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = REG_RSP;
            default:                            src_b = REG_NONE;
        endcase
        case (dreg_icode_q)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:          dst_e = dreg_rb_q;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     dst_e = REG_RSP;
            default:                            dst_e = REG_NONE;
        endcase
        case (dreg_icode_q)
            I_MRMOVQ, I_POPQ:                   dst_m = dreg_ra_q;
            default:                            dst_m = REG_NONE;
        endcase
    end

    // Operand selection. Forwards are checked youngest first so the most
    // recent producer of a register wins; an address of 4'hf never forwards.
    always_comb begin
        d_val_a = bus.valA;
        if ((dreg_icode_q == I_CALL) || (dreg_icode_q == I_JXX))
            d_val_a = dreg_valp_q;
        else if ((src_a != REG_NONE) && (src_a == bus.e_dstE))
            d_val_a = bus.e_valE;
        else if ((src_a != REG_NONE) && (src_a == bus.M_dstM))
            d_val_a = bus.m_valM;
        else if ((src_a != REG_NONE) && (src_a == bus.M_dstE))
            d_val_a = bus.M_valE;
        else if ((src_a != REG_NONE) && (src_a == bus.W_dstM))
            d_val_a = bus.W_valM;
        else if ((src_a != REG_NONE) && (src_a == bus.W_dstE))
            d_val_a = bus.W_valE;

        d_val_b = bus.valB;
        if ((src_b != REG_NONE) && (src_b == bus.e_dstE))
            d_val_b = bus.e_valE;
        else if ((src_b != REG_NONE) && (src_b == bus.M_dstM))
            d_val_b = bus.m_valM;
        else if ((src_b != REG_NONE) && (src_b == bus.M_dstE))
            d_val_b = bus.M_valE;
        else if ((src_b != REG_NONE) && (src_b == bus.W_dstM))
            d_val_b = bus.W_valM;
        else if ((src_b != REG_NONE) && (src_b == bus.W_dstE))
            d_val_b = bus.W_valE;
    end

    // E register next state; D_stall deliberately has no effect here.
    always_comb begin
        ereg_icode_d = dreg_icode_q;
        ereg_ifun_d  = dreg_ifun_q;
        ereg_stat_d  = dreg_stat_q;
        ereg_valc_d  = dreg_valc_q;
        ereg_vala_d  = d_val_a;
        ereg_valb_d  = d_val_b;
        ereg_dste_d  = dst_e;
        ereg_dstm_d  = dst_m;
        ereg_srca_d  = src_a;
        ereg_srcb_d  = src_b;
        if (bus.E_bubble) begin
            ereg_icode_d = I_NOP;
            ereg_ifun_d  = 4'h0;
            ereg_stat_d  = STAT_AOK;
            ereg_valc_d  = 64'h0;
            ereg_vala_d  = 64'h0;
            ereg_valb_d  = 64'h0;
            ereg_dste_d  = REG_NONE;
            ereg_dstm_d  = REG_NONE;
            ereg_srca_d  = REG_NONE;
            ereg_srcb_d  = REG_NONE;
        end
    end

    // Pipeline registers; reset forces both to bubble contents at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dreg_icode_q <= I_NOP;
            dreg_ifun_q  <= 4'h0;
            dreg_ra_q    <= REG_NONE;
            dreg_rb_q    <= REG_NONE;
            dreg_valc_q  <= 64'h0;
            dreg_valp_q  <= 64'h0;
            dreg_stat_q  <= STAT_AOK;
            ereg_icode_q <= I_NOP;
            ereg_ifun_q  <= 4'h0;
            ereg_stat_q  <= STAT_AOK;
            ereg_valc_q  <= 64'h0;
            ereg_vala_q  <= 64'h0;
            ereg_valb_q  <= 64'h0;
            ereg_dste_q  <= REG_NONE;
            ereg_dstm_q  <= REG_NONE;
            ereg_srca_q  <= REG_NONE;
            ereg_srcb_q  <= REG_NONE;
        end else begin
            dreg_icode_q <= dreg_icode_d;
            dreg_ifun_q  <= dreg_ifun_d;
            dreg_ra_q    <= dreg_ra_d;
            dreg_rb_q    <= dreg_rb_d;
            dreg_valc_q  <= dreg_valc_d;
            dreg_valp_q  <= dreg_valp_d;
            dreg_stat_q  <= dreg_stat_d;
            ereg_icode_q <= ereg_icode_d;
            ereg_ifun_q  <= ereg_ifun_d;
            ereg_stat_q  <= ereg_stat_d;
            ereg_valc_q  <= ereg_valc_d;
            ereg_vala_q  <= ereg_vala_d;
            ereg_valb_q  <= ereg_valb_d;
            ereg_dste_q  <= ereg_dste_d;
            ereg_dstm_q  <= ereg_dstm_d;
            ereg_srca_q  <= ereg_srca_d;
            ereg_srcb_q  <= ereg_srcb_d;
        end
    end

    assign bus.d_srcA  = src_a;
    assign bus.d_srcB  = src_b;
    assign bus.E_icode = ereg_icode_q;
    assign bus.E_ifun  = ereg_ifun_q;
    assign bus.E_stat  = ereg_stat_q;
    assign bus.E_valC  = ereg_valc_q;
    assign bus.E_valA  = ereg_vala_q;
    assign bus.E_valB  = ereg_valb_q;
    assign bus.E_dstE  = ereg_dste_q;
    assign bus.E_dstM  = ereg_dstm_q;
    assign bus.E_srcA  = ereg_srca_q;
    assign bus.E_srcB  = ereg_srcb_q;

    // A load in E whose destination is about to be read in D cannot be
    // forwarded in time.
    assign bus.d_loaduse = ((ereg_icode_q == I_MRMOVQ) || (ereg_icode_q == I_POPQ))
                         && (ereg_dstm_q != REG_NONE)
                         && ((ereg_dstm_q == src_a) || (ereg_dstm_q == src_b));
endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage. Directed instruction sequences drive the
// fetch fields, forwards and pipeline controls; after each clock edge the
// hand-computed E register, d_srcA/d_srcB and d_loaduse expected at that
// point are queued, and a separate monitor pops and compares them.
module tb_decode_stage;
    localparam logic [3:0] NONE = 4'hf;

    typedef struct {
        int          id;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [2:0]  stat;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [3:0]  srca;
        logic [3:0]  srcb;
        logic        lu;
        logic [3:0]  dsa;
        logic [3:0]  dsb;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        sample_tick = 1'b0;
    logic [63:0] rf [16];
    exp_t        sb_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          item_id = 0;

    decode_stage_if bus ();

    decode_stage dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Register file read model: address 4'hf reads as zero.
    assign bus.valA = (bus.d_srcA == NONE) ? 64'h0 : rf[bus.d_srcA];
    assign bus.valB = (bus.d_srcB == NONE) ? 64'h0 : rf[bus.d_srcB];

    function automatic exp_t ee(input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [2:0] stat, input logic [63:0] valc,
                                input logic [63:0] vala, input logic [63:0] valb,
                                input logic [3:0] dste, input logic [3:0] dstm,
                                input logic [3:0] srca, input logic [3:0] srcb,
                                input logic lu, input logic [3:0] dsa,
                                input logic [3:0] dsb);
        exp_t e;
        e.id = 0;
        e.icode = icode; e.ifun = ifun; e.stat = stat; e.valc = valc;
        e.vala = vala;   e.valb = valb; e.dste = dste; e.dstm = dstm;
        e.srca = srca;   e.srcb = srcb; e.lu = lu;     e.dsa = dsa;
        e.dsb = dsb;
        return e;
    endfunction

    // Bubble in E, with the decode addresses of whatever now sits in D.
    function automatic exp_t bub(input logic [3:0] dsa, input logic [3:0] dsb);
        return ee(4'h1, 4'h0, 3'd1, 64'h0, 64'h0, 64'h0, NONE, NONE, NONE, NONE,
                  1'b0, dsa, dsb);
    endfunction

    task automatic setFetch(input logic [3:0] icode, input logic [3:0] ifun,
                            input logic [3:0] ra, input logic [3:0] rb,
                            input logic [63:0] valc, input logic [63:0] valp,
                            input logic [2:0] stat);
        bus.f_icode = icode; bus.f_ifun = ifun; bus.f_rA = ra; bus.f_rB = rb;
        bus.f_valC = valc;   bus.f_valP = valp; bus.f_stat = stat;
    endtask

    task automatic setNop(input logic [63:0] valp);
        setFetch(4'h1, 4'h0, NONE, NONE, 64'h0, valp, 3'd1);
    endtask

    task automatic setFwd(input logic [3:0] ed, input logic [63:0] ev,
                          input logic [3:0] mmd, input logic [63:0] mmv,
                          input logic [3:0] med, input logic [63:0] mev,
                          input logic [3:0] wmd, input logic [63:0] wmv,
                          input logic [3:0] wed, input logic [63:0] wev);
        bus.e_dstE = ed;  bus.e_valE = ev;
        bus.M_dstM = mmd; bus.m_valM = mmv;
        bus.M_dstE = med; bus.M_valE = mev;
        bus.W_dstM = wmd; bus.W_valM = wmv;
        bus.W_dstE = wed; bus.W_valE = wev;
    endtask

    task automatic setFwdNone();
        setFwd(NONE, 64'h0, NONE, 64'h0, NONE, 64'h0, NONE, 64'h0, NONE, 64'h0);
    endtask

    task automatic setCtrl(input logic ds, input logic db, input logic eb);
        bus.D_stall = ds; bus.D_bubble = db; bus.E_bubble = eb;
    endtask

    // Clock the current inputs in, then queue what must be visible after the edge.
    task automatic applyStimulus(input exp_t e);
        exp_t t;
        t = e;
        @(posedge clk_i);
        t.id = item_id;
        item_id++;
        sb_q.push_back(t);
        #1;
    endtask

    task automatic cmp(input int id, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL item %0d %s: got 0x%0h expected 0x%0h", id, name, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp(e.id, "E_icode",   64'(bus.E_icode),   64'(e.icode));
        cmp(e.id, "E_ifun",    64'(bus.E_ifun),    64'(e.ifun));
        cmp(e.id, "E_stat",    64'(bus.E_stat),    64'(e.stat));
        cmp(e.id, "E_valC",    bus.E_valC,         e.valc);
        cmp(e.id, "E_valA",    bus.E_valA,         e.vala);
        cmp(e.id, "E_valB",    bus.E_valB,         e.valb);
        cmp(e.id, "E_dstE",    64'(bus.E_dstE),    64'(e.dste));
        cmp(e.id, "E_dstM",    64'(bus.E_dstM),    64'(e.dstm));
        cmp(e.id, "E_srcA",    64'(bus.E_srcA),    64'(e.srca));
        cmp(e.id, "E_srcB",    64'(bus.E_srcB),    64'(e.srcb));
        cmp(e.id, "d_loaduse", 64'(bus.d_loaduse), 64'(e.lu));
        cmp(e.id, "d_srcA",    64'(bus.d_srcA),    64'(e.dsa));
        cmp(e.id, "d_srcB",    64'(bus.d_srcB),    64'(e.dsb));
    endtask

    // Monitor: samples mid-cycle, or on demand for the between-edge reset check.
    initial begin
        exp_t cur;
        forever begin
            @(negedge clk_i or posedge sample_tick);
            if (sb_q.size() > 0) begin
                cur = sb_q.pop_front();
                checkOutput(cur);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 64'h1000 + 64'(i);
        rf[2] = 64'h5;
        rf[3] = 64'h7;

        // Reset held with a live OPQ on fetch: D and E must stay bubbles.
        setCtrl(1'b0, 1'b0, 1'b0);
        setFwdNone();
        setFetch(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0A, 3'd1);
        repeat (2) @(posedge clk_i);
        applyStimulus(bub(NONE, NONE));
        rst_i = 1'b0;

        // Plain OPQ through both registers.
        applyStimulus(bub(4'h2, 4'h3));
        setNop(64'h0C);
        applyStimulus(ee(4'h6, 4'h0, 3'd1, 64'h0, 64'h5, 64'h7, 4'h3, NONE, 4'h2, 4'h3, 1'b0, NONE, NONE));

        // Forward priority: e_dstE beats M_dstE beats W_dstE.
        setFetch(4'h6, 4'h0, 4'h2, 4'h5, 64'h0, 64'h20, 3'd1);
        applyStimulus(bub(4'h2, 4'h5));
        setFwd(4'h2, 64'h11, NONE, 64'h0, 4'h2, 64'h22, NONE, 64'h0, 4'h2, 64'h33);
        setNop(64'h22);
        applyStimulus(ee(4'h6, 4'h0, 3'd1, 64'h0, 64'h11, 64'h1005, 4'h5, NONE, 4'h2, 4'h5, 1'b0, NONE, NONE));
        setFetch(4'h6, 4'h0, 4'h2, 4'h5, 64'h0, 64'h22, 3'd1);
        applyStimulus(bub(4'h2, 4'h5));
        setFwd(NONE, 64'h0, NONE, 64'h0, 4'h2, 64'h22, NONE, 64'h0, 4'h2, 64'h33);
        setNop(64'h24);
        applyStimulus(ee(4'h6, 4'h0, 3'd1, 64'h0, 64'h22, 64'h1005, 4'h5, NONE, 4'h2, 4'h5, 1'b0, NONE, NONE));

        // M_dstM beats M_dstE; W_dstM beats W_dstE.
        setFwd(NONE, 64'h0, 4'h2, 64'h44, 4'h2, 64'h22, 4'h7, 64'h77, 4'h7, 64'h78);
        setFetch(4'h6, 4'h0, 4'h7, 4'h2, 64'h0, 64'h24, 3'd1);
        applyStimulus(bub(4'h7, 4'h2));
        setNop(64'h26);
        applyStimulus(ee(4'h6, 4'h0, 3'd1, 64'h0, 64'h77, 64'h44, 4'h2, NONE, 4'h7, 4'h2, 1'b0, NONE, NONE));

        // CALL takes valP for valA and RSP as srcB/dstE.
        setFwdNone();
        setFetch(4'h8, 4'h0, NONE, NONE, 64'h200, 64'h40, 3'd1);
        applyStimulus(bub(NONE, 4'h4));
        setNop(64'h42);
        applyStimulus(ee(4'h8, 4'h0, 3'd1, 64'h200, 64'h40, 64'h1004, 4'h4, NONE, NONE, 4'h4, 1'b0, NONE, NONE));

        // Register-file fallback for valA, W_dstE forward for valB.
        setFetch(4'h6, 4'h0, 4'h9, 4'hA, 64'h0, 64'h30, 3'd1);
        applyStimulus(bub(4'h9, 4'hA));
        setFwd(NONE, 64'h0, NONE, 64'h0, NONE, 64'h0, NONE, 64'h0, 4'hA, 64'hA0A);
        setNop(64'h32);
        applyStimulus(ee(4'h6, 4'h0, 3'd1, 64'h0, 64'h1009, 64'hA0A, 4'hA, NONE, 4'h9, 4'hA, 1'b0, NONE, NONE));

        // Load-use: MRMOVQ into r1 followed by OPQ reading r1.
        setFwdNone();
        setFetch(4'h5, 4'h0, 4'h1, 4'h3, 64'h8, 64'h50, 3'd1);
        applyStimulus(bub(NONE, 4'h3));
        setFetch(4'h6, 4'h0, 4'h1, 4'h4, 64'h0, 64'h52, 3'd1);
        applyStimulus(ee(4'h5, 4'h0, 3'd1, 64'h8, 64'h0, 64'h7, NONE, 4'h1, NONE, 4'h3, 1'b1, 4'h1, 4'h4));
        setCtrl(1'b1, 1'b0, 1'b1);
        setNop(64'h54);
        applyStimulus(bub(4'h1, 4'h4));
        setCtrl(1'b0, 1'b0, 1'b0);
        setFwd(NONE, 64'h0, 4'h1, 64'h5A, NONE, 64'h0, NONE, 64'h0, NONE, 64'h0);
        applyStimulus(ee(4'h6, 4'h0, 3'd1, 64'h0, 64'h5A, 64'h1004, 4'h4, NONE, 4'h1, 4'h4, 1'b0, NONE, NONE));

        // D_stall with D_bubble holds D; E keeps flowing; then D_bubble alone.
        setFwdNone();
        setFetch(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h60, 3'd1);
        applyStimulus(bub(4'h2, 4'h3));
        setCtrl(1'b1, 1'b1, 1'b0);
        setFetch(4'h3, 4'h0, NONE, 4'h6, 64'h123, 64'h6A, 3'd1);
        applyStimulus(ee(4'h6, 4'h0, 3'd1, 64'h0, 64'h5, 64'h7, 4'h3, NONE, 4'h2, 4'h3, 1'b0, 4'h2, 4'h3));
        setCtrl(1'b0, 1'b1, 1'b0);
        applyStimulus(ee(4'h6, 4'h0, 3'd1, 64'h0, 64'h5, 64'h7, 4'h3, NONE, 4'h2, 4'h3, 1'b0, NONE, NONE));
        setCtrl(1'b0, 1'b0, 1'b0);
        applyStimulus(bub(NONE, NONE));
        setNop(64'h6C);
        applyStimulus(ee(4'h3, 4'h0, 3'd1, 64'h123, 64'h0, 64'h0, 4'h6, NONE, NONE, NONE, 1'b0, NONE, NONE));

        // Status propagation (HLT).
        setFetch(4'h0, 4'h0, NONE, NONE, 64'h0, 64'h70, 3'd2);
        applyStimulus(bub(NONE, NONE));
        setNop(64'h72);
        applyStimulus(ee(4'h0, 4'h0, 3'd2, 64'h0, 64'h0, 64'h0, NONE, NONE, NONE, NONE, 1'b0, NONE, NONE));

        // Mid-stream asynchronous reset with OPQ sitting in E.
        setFetch(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h80, 3'd1);
        applyStimulus(bub(4'h2, 4'h3));
        setNop(64'h82);
        applyStimulus(ee(4'h6, 4'h0, 3'd1, 64'h0, 64'h5, 64'h7, 4'h3, NONE, 4'h2, 4'h3, 1'b0, NONE, NONE));
        @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        begin
            exp_t r;
            r = bub(NONE, NONE);
            r.id = item_id;
            item_id++;
            sb_q.push_back(r);
        end
        #1 sample_tick = 1'b1;
        #1 sample_tick = 1'b0;
        setFetch(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h90, 3'd1);
        applyStimulus(bub(NONE, NONE));
        rst_i = 1'b0;
        applyStimulus(bub(4'h2, 4'h3));
        setNop(64'h92);
        applyStimulus(ee(4'h6, 4'h0, 3'd1, 64'h0, 64'h5, 64'h7, 4'h3, NONE, 4'h2, 4'h3, 1'b0, NONE, NONE));

        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk_i);
            #1;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: %0d items left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
